// File: rtl/frame_buffer_pingpong_pkg.sv
// Shared types and constants for the ping-pong frame store.
// Latency: none (declarations only).
// Backpressure: n/a.
package frame_buffer_pingpong_pkg;

    // Write-side FSM: FILL accepts pixels, HOLD freezes the bank until the reader lets go.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } wr_state_e;

    // Read pipeline depth limits: 1 = RAM register only, 2 = extra output register.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/frame_buffer_pingpong_ram_sdp_bank.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
// Latency: read data appears one cycle after i_rd_en; write lands at the next edge.
// Backpressure: none; output register holds its value while i_rd_en is low.
module ram_sdp_bank #(
    parameter int DEPTH  = 4800,
    parameter int WIDTH  = 12,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage is never reset; callers gate enables so addresses stay in range.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: writer fills one bank while the reader scans the other.
// Latency: rd_valid/rd_data follow rd_en by READ_LATENCY (1 or 2) cycles.
// Backpressure: none; writes arriving while the write bank is frozen are dropped and flagged.
module frame_buffer_pingpong
    import frame_buffer_pingpong_pkg::*;
#(
    parameter int DEPTH        = 4800,
    parameter int WIDTH        = 12,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_frame_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_frame_done,
    output logic              frame_valid,
    output logic              wr_bank,
    output logic              wr_overflow
);

    if (!rd_lat_legal(READ_LATENCY)) begin : g_bad_latency
        $error("frame_buffer_pingpong: READ_LATENCY must be 1 or 2");
    end

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    wr_state_e        r_state;
    wr_state_e        w_state_nxt;
    logic             w_swap;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             r_rd_released;
    logic             r_frame_valid;
    logic             r_wr_overflow;

    logic             w_wr_in_range;
    logic             w_wr_go;
    logic             w_rd_in_range;
    logic             w_rd_go;
    logic [WIDTH-1:0] w_q0;
    logic [WIDTH-1:0] w_q1;

    logic             r_s1_vld;
    logic             r_s1_bank;
    logic             r_s1_zero;
    logic [WIDTH-1:0] w_s1_dat;

    assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);
    assign w_wr_go       = (r_state == ST_FILL) && wr_en && w_wr_in_range;
    assign w_rd_go       = rd_en && w_rd_in_range;

    // Write FSM next state; swap fires from HOLD once the reader has released its bank.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (wr_frame_done) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_rd_released) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bank ownership, reader release handshake and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b1;
            r_rd_released <= 1'b1;
            r_frame_valid <= 1'b0;
            r_wr_overflow <= 1'b0;
        end else begin
            if (w_swap) begin
                r_wr_bank     <= ~r_wr_bank;
                r_rd_bank     <= ~r_rd_bank;
                r_frame_valid <= 1'b1;
                r_rd_released <= 1'b0;
            end else if (rd_frame_done) begin
                r_rd_released <= 1'b1;
            end
            if ((r_state == ST_HOLD) && (wr_en || wr_frame_done)) begin
                r_wr_overflow <= 1'b1;
            end
        end
    end

    ram_sdp_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank0 (
        .i_clk     (clk),
        .i_wr_en   (w_wr_go && !r_wr_bank),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_go && !r_rd_bank),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_q0)
    );

    ram_sdp_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank1 (
        .i_clk     (clk),
        .i_wr_en   (w_wr_go && r_wr_bank),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_go && r_rd_bank),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_q1)
    );

    // First read stage tracks the RAM access: bank is captured at issue so a read
    // launched in the swap cycle still returns the old bank; out-of-range reads yield zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_bank <= 1'b0;
            r_s1_zero <= 1'b1;
        end else begin
            r_s1_vld <= rd_en;
            if (rd_en) begin
                r_s1_bank <= r_rd_bank;
                r_s1_zero <= !w_rd_in_range;
            end
        end
    end

    assign w_s1_dat = r_s1_zero ? '0 : (r_s1_bank ? w_q1 : w_q0);

    if (READ_LATENCY == 2) begin : g_lat2
        logic             r_s2_vld;
        logic [WIDTH-1:0] r_s2_dat;

        // Optional output register; data only moves on a valid beat so it holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_vld <= 1'b0;
                r_s2_dat <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_dat <= w_s1_dat;
                end
            end
        end

        assign rd_valid = r_s2_vld;
        assign rd_data  = r_s2_dat;
    end else begin : g_lat1
        assign rd_valid = r_s1_vld;
        assign rd_data  = w_s1_dat;
    end

    assign frame_valid = r_frame_valid;
    assign wr_bank     = r_wr_bank;
    assign wr_overflow = r_wr_overflow;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench: dut_a is 16 deep with latency 1, dut_b is 20 deep with latency 2.
// Both share the same stimulus; checks target whichever instance shows the behaviour.
// Inputs driven #1 after posedge, outputs sampled #1 after posedge.
module tb_frame_buffer_pingpong;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_frame_done;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic       rd_frame_done;

    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic       frame_valid_a, frame_valid_b;
    logic       wr_bank_a, wr_bank_b;
    logic       wr_overflow_a, wr_overflow_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    frame_buffer_pingpong #(.DEPTH(16), .WIDTH(8), .READ_LATENCY(1)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr[3:0]),
        .wr_data       (wr_data),
        .wr_frame_done (wr_frame_done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr[3:0]),
        .rd_data       (rd_data_a),
        .rd_valid      (rd_valid_a),
        .rd_frame_done (rd_frame_done),
        .frame_valid   (frame_valid_a),
        .wr_bank       (wr_bank_a),
        .wr_overflow   (wr_overflow_a)
    );

    frame_buffer_pingpong #(.DEPTH(20), .WIDTH(8), .READ_LATENCY(2)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_frame_done (wr_frame_done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data_b),
        .rd_valid      (rd_valid_b),
        .rd_frame_done (rd_frame_done),
        .frame_valid   (frame_valid_b),
        .wr_bank       (wr_bank_b),
        .wr_overflow   (wr_overflow_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en         = 1'b0;
        wr_frame_done = 1'b0;
        rd_en         = 1'b0;
        rd_frame_done = 1'b0;
    endtask

    // Writes base+i to addresses 0..n-1, pulsing wr_frame_done with the last word when asked.
    task automatic write_block(input int n, input logic [7:0] base, input bit done_last);
        for (int i = 0; i < n; i++) begin
            wr_en         = 1'b1;
            wr_addr       = 5'(i);
            wr_data       = base + 8'(i);
            wr_frame_done = done_last && (i == n - 1);
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        rst     = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check_eq("rst_rd_data",     rd_data_a,     0);
        check_eq("rst_rd_valid",    rd_valid_a,    0);
        check_eq("rst_frame_valid", frame_valid_a, 0);
        check_eq("rst_wr_bank",     wr_bank_a,     0);
        check_eq("rst_overflow",    wr_overflow_a, 0);
        check_eq("rst_rd_data_b",   rd_data_b,     0);

        // First frame: last write coincides with wr_frame_done, swap one edge later.
        write_block(16, 8'h10, 1'b1);
        check_eq("hold_wr_bank",     wr_bank_a,     0);
        check_eq("hold_frame_valid", frame_valid_a, 0);
        step();
        check_eq("swap1_frame_valid", frame_valid_a, 1);
        check_eq("swap1_wr_bank",     wr_bank_a,     1);

        // Read addr 5 from the completed bank.
        rd_en = 1'b1; rd_addr = 5'd5;
        step();
        rd_en = 1'b0;
        check_eq("rd5_valid_a",  rd_valid_a, 1);
        check_eq("rd5_data_a",   rd_data_a,  8'h15);
        check_eq("rd5_valid_b0", rd_valid_b, 0);
        step();
        check_eq("rd5_valid_a_off", rd_valid_a, 0);
        check_eq("rd5_hold_a",      rd_data_a,  8'h15);
        check_eq("rd5_valid_b1",    rd_valid_b, 1);
        check_eq("rd5_data_b",      rd_data_b,  8'h15);

        // Second frame without reader release: stays in HOLD.
        write_block(16, 8'hA0, 1'b1);
        step();
        check_eq("hold2_wr_bank",  wr_bank_a,     1);
        check_eq("hold2_overflow", wr_overflow_a, 0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF;
        step();
        idle();
        check_eq("hold2_overflow_set", wr_overflow_a, 1);
        rd_en = 1'b1; rd_addr = 5'd7;
        step();
        rd_en = 1'b0;
        check_eq("hold2_rd7", rd_data_a, 8'h17);

        // Reader releases; the next edge swaps. Read and write issued in that swap cycle.
        rd_frame_done = 1'b1;
        step();
        rd_frame_done = 1'b0;
        check_eq("rel_wr_bank", wr_bank_a, 1);
        rd_en = 1'b1; rd_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'hEE;
        step();
        idle();
        check_eq("swap2_wr_bank", wr_bank_a,  0);
        check_eq("swapcyc_rd3",   rd_data_a,  8'h13);
        check_eq("swapcyc_vld",   rd_valid_a, 1);
        rd_en = 1'b1; rd_addr = 5'd3;
        step();
        check_eq("new_rd3", rd_data_a, 8'hA3);
        rd_addr = 5'd0;
        step();
        rd_en = 1'b0;
        check_eq("new_rd0", rd_data_a, 8'hA0);

        // Simultaneous wr_frame_done and rd_frame_done: exactly one swap, one edge later.
        write_block(3, 8'hC0, 1'b0);
        wr_frame_done = 1'b1; rd_frame_done = 1'b1;
        step();
        idle();
        check_eq("simul_hold_bank", wr_bank_a, 0);
        step();
        check_eq("simul_swap_bank", wr_bank_a, 1);
        step();
        check_eq("simul_once_bank", wr_bank_a, 1);

        // Latency-2 instance: back-to-back reads 0,1,2.
        rd_en = 1'b1; rd_addr = 5'd0;
        step();
        check_eq("l2_v0", rd_valid_b, 0);
        rd_addr = 5'd1;
        step();
        check_eq("l2_v1", rd_valid_b, 1);
        check_eq("l2_d0", rd_data_b,  8'hC0);
        rd_addr = 5'd2;
        step();
        rd_en = 1'b0;
        check_eq("l2_v2", rd_valid_b, 1);
        check_eq("l2_d1", rd_data_b,  8'hC1);
        step();
        check_eq("l2_v3", rd_valid_b, 1);
        check_eq("l2_d2", rd_data_b,  8'hC2);
        step();
        check_eq("l2_v4",    rd_valid_b, 0);
        check_eq("l2_hold2", rd_data_b,  8'hC2);

        // Out-of-range read on the 20-deep instance.
        rd_en = 1'b1; rd_addr = 5'd20;
        step();
        rd_en = 1'b0;
        step();
        check_eq("oor_valid", rd_valid_b, 1);
        check_eq("oor_data",  rd_data_b,  0);

        // Mid-frame reset with a read in flight.
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'h77;
        step();
        idle();
        rd_en = 1'b1; rd_addr = 5'd1;
        step();
        rd_en = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mrst_valid_a",    rd_valid_a,    0);
        check_eq("mrst_valid_b",    rd_valid_b,    0);
        check_eq("mrst_wr_bank",    wr_bank_a,     0);
        check_eq("mrst_frame_vld",  frame_valid_a, 0);
        check_eq("mrst_overflow",   wr_overflow_a, 0);
        check_eq("mrst_rd_data_a",  rd_data_a,     0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
